// File: rtl/arb_pkg.sv
// Shared definitions for the requester/arbiter slice.
// Holds the default channel count, queue depth and starvation limit, plus
// helpers that size the per-channel pending and wait counters. The
// round-robin arbiter uses the same package, so both sides agree on N.
package arb_pkg;

   localparam int unsigned N_DEF            = 4;
   localparam int unsigned DEPTH_DEF        = 4;
   localparam int unsigned STARVE_LIMIT_DEF = 8;

   // Width able to hold 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Width able to hold 0..limit inclusive (wait counter saturates at limit).
   function automatic int unsigned wt_width(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

   localparam int unsigned CNT_W = cnt_width(DEPTH_DEF);
   localparam int unsigned WT_W  = wt_width(STARVE_LIMIT_DEF);

endpackage

// File: rtl/arb_req_channel.sv
// One requester channel: pending-request counter, wait counter and done pulse.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push          new request strobe for this channel
//   gnt           grant bit from the arbiter for this channel
//   req           request to arbiter (pending count non-zero)
//   full          pending count at DEPTH
//   done          one-cycle pulse after each accepted grant
//   starve        channel has waited STARVE_LIMIT cycles or more
//   overflow_stb  push dropped this cycle (combinational strobe)
//   spurious_stb  grant seen while not requesting (combinational strobe)
module arb_req_channel
   import arb_pkg::*;
#(
   parameter int unsigned DEPTH        = DEPTH_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic gnt,
   output logic req,
   output logic full,
   output logic done,
   output logic starve,
   output logic overflow_stb,
   output logic spurious_stb
);

   localparam int unsigned CW = cnt_width(DEPTH);
   localparam int unsigned WW = wt_width(STARVE_LIMIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
   localparam logic [WW-1:0] WT_MAX  = WW'(STARVE_LIMIT);

   logic [CW-1:0] cnt_r;
   logic [WW-1:0] wt_r;
   logic          done_r;
   logic          req_s;
   logic          full_s;
   logic          accept_s;

   // Request and full are decoded only from registered state, so there is no
   // combinational path from push or gnt to the arbiter.
   assign req_s    = (cnt_r != {CW{1'b0}});
   assign full_s   = (cnt_r == CNT_MAX);
   assign accept_s = gnt & req_s;

   assign req          = req_s;
   assign full         = full_s;
   assign done         = done_r;
   assign starve       = (wt_r >= WT_MAX);
   // A push alongside an accepted grant always fits, even when full.
   assign overflow_stb = push & full_s & ~accept_s;
   assign spurious_stb = gnt & ~req_s;

   // Pending count, wait counter and done pulse state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= {CW{1'b0}};
         wt_r   <= {WW{1'b0}};
         done_r <= 1'b0;
      end else begin
         done_r <= accept_s;
         case ({push, accept_s})
            2'b01: cnt_r <= cnt_r - CW'(1);
            2'b10: begin
               if (!full_s) cnt_r <= cnt_r + CW'(1);
               else         cnt_r <= cnt_r;
            end
            default: cnt_r <= cnt_r;
         endcase
         if (!req_s || accept_s)  wt_r <= {WW{1'b0}};
         else if (wt_r != WT_MAX) wt_r <= wt_r + WW'(1);
         else                     wt_r <= wt_r;
      end
   end

endmodule

// File: rtl/arb_requester.sv
// N-channel request front end for a round-robin arbiter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push[N]      per-channel new-request strobes
//   GNT[N]       grant vector from the arbiter
//   REQ[N]       request vector to the arbiter
//   full[N]      channel pending count at DEPTH
//   done[N]      one-cycle pulse per serviced request
//   starve[N]    channel waited STARVE_LIMIT cycles or more
//   overflow     sticky: a push was dropped on a full channel
//   spurious     sticky: a grant arrived on a channel not requesting
//   multi_grant  sticky: more than one grant bit in a cycle
module arb_requester
   import arb_pkg::*;
#(
   parameter int unsigned N            = N_DEF,
   parameter int unsigned DEPTH        = DEPTH_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] push,
   input  logic [N-1:0] GNT,
   output logic [N-1:0] REQ,
   output logic [N-1:0] full,
   output logic [N-1:0] done,
   output logic [N-1:0] starve,
   output logic         overflow,
   output logic         spurious,
   output logic         multi_grant
);

   logic [N-1:0] ovf_stb_s;
   logic [N-1:0] spur_stb_s;
   logic         multi_s;
   logic         overflow_r;
   logic         spurious_r;
   logic         multi_grant_r;

   for (genvar i = 0; i < N; i++) begin : g_ch
      arb_req_channel #(
         .DEPTH        (DEPTH),
         .STARVE_LIMIT (STARVE_LIMIT)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .push         (push[i]),
         .gnt          (GNT[i]),
         .req          (REQ[i]),
         .full         (full[i]),
         .done         (done[i]),
         .starve       (starve[i]),
         .overflow_stb (ovf_stb_s[i]),
         .spurious_stb (spur_stb_s[i])
      );
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_s = ((GNT & (GNT - N'(1))) != {N{1'b0}});

   assign overflow    = overflow_r;
   assign spurious    = spurious_r;
   assign multi_grant = multi_grant_r;

   // Sticky error flags; only reset clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r    <= 1'b0;
         spurious_r    <= 1'b0;
         multi_grant_r <= 1'b0;
      end else begin
         overflow_r    <= overflow_r    | (|ovf_stb_s);
         spurious_r    <= spurious_r    | (|spur_stb_s);
         multi_grant_r <= multi_grant_r | multi_s;
      end
   end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester with a behavioural channel model and
// a behavioural round-robin arbiter for the closed-loop run.
module tb_arb_requester;

   localparam int NCH = 4;
   localparam int DEP = 4;
   localparam int LIM = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] push = '0;
   logic [NCH-1:0] GNT = '0;
   logic [NCH-1:0] REQ, full, done, starve;
   logic           overflow, spurious, multi_grant;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // model state
   int       m_cnt [NCH];
   int       m_wt  [NCH];
   bit [3:0] m_done;
   bit       m_ovf, m_spur, m_multi;
   int       rr_ptr;
   int       done_cnt [NCH];

   arb_requester #(.N(NCH), .DEPTH(DEP), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .push(push), .GNT(GNT),
      .REQ(REQ), .full(full), .done(done), .starve(starve),
      .overflow(overflow), .spurious(spurious), .multi_grant(multi_grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] e_req();
      logic [3:0] v = 4'b0000;
      for (int i = 0; i < NCH; i++) v[i] = (m_cnt[i] > 0);
      return v;
   endfunction

   function automatic logic [3:0] e_full();
      logic [3:0] v = 4'b0000;
      for (int i = 0; i < NCH; i++) v[i] = (m_cnt[i] == DEP);
      return v;
   endfunction

   function automatic logic [3:0] e_starve();
      logic [3:0] v = 4'b0000;
      for (int i = 0; i < NCH; i++) v[i] = (m_wt[i] >= LIM);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = 0;
         m_wt[i]  = 0;
      end
      m_done = 4'b0000;
      m_ovf = 1'b0; m_spur = 1'b0; m_multi = 1'b0;
      rr_ptr = 0;
   endtask

   // One clock of the requirements: a pending queue per channel.
   task automatic model_step(input logic [3:0] p, input logic [3:0] g);
      if ($countones(g) > 1) m_multi = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         bit waiting = (m_cnt[i] > 0);
         bit served  = g[i] && waiting;
         if (g[i] && !waiting) m_spur = 1'b1;
         m_done[i] = served;
         if (served && !p[i])      m_cnt[i]--;
         else if (p[i] && !served) begin
            if (m_cnt[i] < DEP) m_cnt[i]++;
            else                m_ovf = 1'b1;
         end
         if (!waiting || served) m_wt[i] = 0;
         else if (m_wt[i] < LIM) m_wt[i]++;
      end
   endtask

   // Round-robin pick from the model's pending state, starting at rr_ptr.
   function automatic logic [3:0] rr_pick();
      logic [3:0] g = 4'b0000;
      for (int k = 0; k < NCH; k++) begin
         int idx = (rr_ptr + k) % NCH;
         if (m_cnt[idx] > 0) begin
            g[idx] = 1'b1;
            rr_ptr = (idx + 1) % NCH;
            break;
         end
      end
      return g;
   endfunction

   // Inputs change at the falling edge; the model follows the rising edge.
   task automatic cycle(input logic [3:0] p, input logic [3:0] g);
      push = p;
      GNT  = g;
      @(posedge clk);
      model_step(p, g);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_REQ", REQ, 4'b0000);
      check("rst_done", done, 4'b0000);
      check("rst_flags", {1'b0, overflow, spurious, multi_grant}, 4'b0000);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("REQ", REQ, e_req());
         check("full", full, e_full());
         check("done", done, m_done);
         check("starve", starve, e_starve());
         check("overflow", {3'b000, overflow}, {3'b000, m_ovf});
         check("spurious", {3'b000, spurious}, {3'b000, m_spur});
         check("multi_grant", {3'b000, multi_grant}, {3'b000, m_multi});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #2;
      check("reset_REQ", REQ, 4'b0000);
      check("reset_full", full, 4'b0000);
      check("reset_starve", starve, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Single request, granted two cycles after push.
      cycle(4'b0001, 4'b0000);
      check("t1_req_after_push", REQ, 4'b0001);
      cycle(4'b0000, 4'b0000);
      check("t1_req_held", REQ, 4'b0001);
      cycle(4'b0000, 4'b0001);
      check("t1_done", done, 4'b0001);
      check("t1_req_cleared", REQ, 4'b0000);
      cycle(4'b0000, 4'b0000);
      check("t1_done_one_cycle", done, 4'b0000);

      // Fill channel 2 and overrun it.
      for (int k = 0; k < 4; k++) cycle(4'b0100, 4'b0000);
      check("t2_full", full, 4'b0100);
      check("t2_no_ovf_yet", {3'b000, overflow}, 4'b0000);
      cycle(4'b0100, 4'b0000);
      check("t2_overflow", {3'b000, overflow}, 4'b0001);
      for (int k = 0; k < 4; k++) cycle(4'b0000, 4'b0100);
      check("t2_drained", REQ, 4'b0000);

      // Push and grant together on a full channel.
      do_reset();
      for (int k = 0; k < 4; k++) cycle(4'b0010, 4'b0000);
      cycle(4'b0010, 4'b0010);
      check("t3_still_full", full, 4'b0010);
      check("t3_done", done, 4'b0010);
      check("t3_no_ovf", {3'b000, overflow}, 4'b0000);
      for (int k = 0; k < 4; k++) cycle(4'b0000, 4'b0010);

      // Starvation on channel 3.
      cycle(4'b1000, 4'b0000);
      for (int k = 0; k < 7; k++) cycle(4'b0000, 4'b0000);
      check("t4_not_starved", starve, 4'b0000);
      cycle(4'b0000, 4'b0000);
      check("t4_starved", starve, 4'b1000);
      cycle(4'b0000, 4'b0000);
      cycle(4'b0000, 4'b0000);
      cycle(4'b0000, 4'b1000);
      check("t4_starve_cleared", starve, 4'b0000);

      // Spurious grant, then a double grant.
      cycle(4'b0000, 4'b0100);
      check("t5_spurious", {3'b000, spurious}, 4'b0001);
      check("t5_no_done", done, 4'b0000);
      cycle(4'b1010, 4'b0000);
      cycle(4'b0000, 4'b1010);
      check("t5_multi", {3'b000, multi_grant}, 4'b0001);
      check("t5_done", done, 4'b1010);

      // Closed loop with a round-robin arbiter.
      do_reset();
      for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
      for (int c = 0; c < 24; c++) begin
         logic [3:0] g;
         g = rr_pick();
         cycle((c < 4) ? 4'b1111 : 4'b0000, g);
         for (int i = 0; i < NCH; i++) if (done[i] === 1'b1) done_cnt[i]++;
      end
      for (int i = 0; i < NCH; i++) check($sformatf("t6_done_count%0d", i), 4'(done_cnt[i]), 4'd4);
      check("t6_flags", {1'b0, overflow, spurious, multi_grant}, 4'b0000);

      // Reset in the middle of traffic.
      cycle(4'b1111, 4'b0000);
      cycle(4'b1111, 4'b0001);
      #2;
      rst = 1'b1;
      #1;
      check("t7_REQ", REQ, 4'b0000);
      check("t7_full_starve", full | starve, 4'b0000);
      check("t7_done", done, 4'b0000);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(4'b0000, 4'b0000);
      check("t7_no_leftover", REQ, 4'b0000);
      cycle(4'b0001, 4'b0000);
      check("t7_first_push", REQ, 4'b0001);
      cycle(4'b0000, 4'b0001);
      check("t7_first_done", done, 4'b0001);
      cycle(4'b0000, 4'b0000);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
